// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Pipeline sequencing controller for the 5-stage core. It drives the load
// enables and flush/bubble controls of the PC, IF/ID, ID/EX and EX/MEM
// boundaries. It detects load-use hazards and taken-branch redirects, and it
// freezes the whole pipe while data memory is busy. Multi-cycle bubbles and
// flush windows are sequenced by a small FSM with a down-counter.
//
// Optional feature: define HAZARD_PERF_CNT_EN to add the 32-bit stall_count
// and flush_count performance counters.
module hazard_stall_controller #(
    parameter int unsigned LOAD_BUBBLES = 1,  // 1..7 ID/EX bubbles per load-use
    parameter int unsigned FLUSH_CYCLES = 1   // 1..7 IF/ID flush cycles per branch
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic        uses_rs2_id,
    input  logic [4:0]  rd_ex,
    input  logic        MemRead_ex,
    input  logic        branch_taken_ex,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_stall,
    output logic [1:0]  state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        UNUSED   = 2'd3
    } state_t;

    localparam logic [2:0] LB_RELOAD = 3'(LOAD_BUBBLES - 1);
    localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       load_use;

    // Load-use hazard: a load in EX writes a register the ID instruction reads.
    // x0 never hazards, and a match on both sources is still a single hazard.
    assign load_use = MemRead_ex && (rd_ex != 5'd0) &&
                      ((rd_ex == rs1_id) || (uses_rs2_id && (rd_ex == rs2_id)));

    // Zero-latency output decode and next-state selection.
    always_comb begin
        // NOTE: every output and next-state signal gets a default first, so no
        // path through the case/if tree can leave a latch behind.
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;

        if (!reset_n) begin
            // Controls are forced low for the whole reset window, not just at
            // the edge; the registers are cleared asynchronously below.
            state_d = RUN;
            cnt_d   = '0;
        end else if (mem_busy) begin
            // Freeze: nothing moves, state and counter hold, events wait.
            ex_mem_stall = 1'b1;
        end else begin
            case (state_q)
                LU_STALL: begin
                    // EX holds a bubble, so a branch here cannot be real.
                    id_ex_write = 1'b1;
                    id_ex_flush = 1'b1;
                    cnt_d       = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                end

                FLUSH: begin
                    // ID holds a flushed NOP here, so load-use is not evaluated.
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    id_ex_write = 1'b1;
                    if_id_flush = 1'b1;
                    if (branch_taken_ex) begin
                        id_ex_flush = 1'b1;
                        cnt_d       = FL_RELOAD;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                        if (cnt_q <= 3'd1) begin
                            state_d = RUN;
                            cnt_d   = '0;
                        end
                    end
                end

                default: begin  // RUN, and the unused encoding behaves as RUN
                    if (branch_taken_ex) begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        id_ex_write = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = FLUSH;
                            cnt_d   = FL_RELOAD;
                        end
                    end else if (load_use) begin
                        id_ex_write = 1'b1;
                        id_ex_flush = 1'b1;
                        if (LOAD_BUBBLES > 1) begin
                            state_d = LU_STALL;
                            cnt_d   = LB_RELOAD;
                        end
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        id_ex_write = 1'b1;
                    end
                    if (state_q == UNUSED) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                end
            endcase
        end
    end

    // State and bubble/flush counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic count_stall;
    logic count_flush;

    // A load-use bubble is the only case with id_ex_flush=1 and pc_write=0;
    // an accepted branch is the only case with id_ex_flush=1 and pc_write=1.
    assign count_stall = ex_mem_stall | (id_ex_flush & ~pc_write);
    assign count_flush = id_ex_flush & pc_write;

    // Free-running performance counters, wrapping modulo 2^32.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (count_stall) stall_count <= stall_count + 32'd1;
            if (count_flush) flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller
// Two instances share one stimulus stream: dut_a (3 load bubbles, 2 flush
// cycles) and dut_b (1 and 1). Each is compared against a behavioural model
// that tracks "bubbles still owed" and "flush cycles still owed".
// Define HAZARD_PERF_CNT_EN to also check the performance counters.
module tb_hazard_stall_controller;

    localparam int LB_A = 3, FC_A = 2, LB_B = 1, FC_B = 1;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic       uses_rs2_id, MemRead_ex, branch_taken_ex, mem_busy;

    logic       a_pc_write, a_if_id_write, a_id_ex_write, a_if_id_flush, a_id_ex_flush, a_ex_mem_stall;
    logic       b_pc_write, b_if_id_write, b_id_ex_write, b_if_id_flush, b_id_ex_flush, b_ex_mem_stall;
    logic [1:0] a_state, b_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] a_stall_count, a_flush_count, b_stall_count, b_flush_count;
`endif

    hazard_stall_controller #(.LOAD_BUBBLES(LB_A), .FLUSH_CYCLES(FC_A)) dut_a (
        .clock(clock), .reset_n(reset_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .uses_rs2_id(uses_rs2_id), .rd_ex(rd_ex), .MemRead_ex(MemRead_ex),
        .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy),
        .pc_write(a_pc_write), .if_id_write(a_if_id_write), .id_ex_write(a_id_ex_write),
        .if_id_flush(a_if_id_flush), .id_ex_flush(a_id_ex_flush),
        .ex_mem_stall(a_ex_mem_stall), .state(a_state)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_count(a_stall_count), .flush_count(a_flush_count)
`endif
    );

    hazard_stall_controller #(.LOAD_BUBBLES(LB_B), .FLUSH_CYCLES(FC_B)) dut_b (
        .clock(clock), .reset_n(reset_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .uses_rs2_id(uses_rs2_id), .rd_ex(rd_ex), .MemRead_ex(MemRead_ex),
        .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy),
        .pc_write(b_pc_write), .if_id_write(b_if_id_write), .id_ex_write(b_id_ex_write),
        .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush),
        .ex_mem_stall(b_ex_mem_stall), .state(b_state)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_count(b_stall_count), .flush_count(b_flush_count)
`endif
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int step_no = 0;

    // Reference model: cycles of bubbles/flushes still owed plus event counts.
    typedef struct {
        int bub;
        int fl;
        int sc;
        int fc;
    } model_t;

    model_t ma, mb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
        end
    endtask

    // Expected {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_stall}.
    function automatic logic [5:0] exp_ctl(model_t m, bit lu, bit br, bit busy);
        if (busy)     return 6'b000001;
        if (m.bub > 0) return 6'b001010;
        if (m.fl > 0)  return br ? 6'b111110 : 6'b111100;
        if (br)       return 6'b111110;
        if (lu)       return 6'b001010;
        return 6'b111000;
    endfunction

    function automatic logic [1:0] exp_state(model_t m);
        if (m.bub > 0) return 2'd1;
        if (m.fl > 0)  return 2'd2;
        return 2'd0;
    endfunction

    function automatic model_t advance(model_t m, bit lu, bit br, bit busy, int lb, int fc);
        model_t n = m;
        if (busy) begin
            n.sc++;
        end else if (m.bub > 0) begin
            n.sc++;
            n.bub--;
        end else if (br) begin
            n.fc++;
            n.fl = fc - 1;
        end else if (m.fl > 0) begin
            n.fl--;
        end else if (lu) begin
            n.sc++;
            n.bub = lb - 1;
        end
        return n;
    endfunction

    function automatic model_t model_reset();
        model_t m;
        m.bub = 0; m.fl = 0; m.sc = 0; m.fc = 0;
        return m;
    endfunction

    task automatic check_all(input bit lu, input bit br, input bit busy);
        check("a_ctl", 32'({a_pc_write, a_if_id_write, a_id_ex_write, a_if_id_flush, a_id_ex_flush, a_ex_mem_stall}),
              32'(exp_ctl(ma, lu, br, busy)));
        check("a_state", 32'(a_state), 32'(exp_state(ma)));
        check("b_ctl", 32'({b_pc_write, b_if_id_write, b_id_ex_write, b_if_id_flush, b_id_ex_flush, b_ex_mem_stall}),
              32'(exp_ctl(mb, lu, br, busy)));
        check("b_state", 32'(b_state), 32'(exp_state(mb)));
`ifdef HAZARD_PERF_CNT_EN
        check("a_stall_count", a_stall_count, 32'(ma.sc));
        check("a_flush_count", a_flush_count, 32'(ma.fc));
        check("b_stall_count", b_stall_count, 32'(mb.sc));
        check("b_flush_count", b_flush_count, 32'(mb.fc));
`endif
    endtask

    // One cycle: drive after the falling edge, check, then let the rising edge act.
    task automatic step(input bit mr, input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2, input bit u2, input bit br, input bit busy);
        bit lu;
        MemRead_ex      = mr;
        rd_ex           = rd;
        rs1_id          = r1;
        rs2_id          = r2;
        uses_rs2_id     = u2;
        branch_taken_ex = br;
        mem_busy        = busy;
        lu = mr && (rd != 5'd0) && ((rd == r1) || (u2 && (rd == r2)));
        #1;
        step_no++;
        check_all(lu, br, busy);
        @(posedge clock);
        ma = advance(ma, lu, br, busy, LB_A, FC_A);
        mb = advance(mb, lu, br, busy, LB_B, FC_B);
        @(negedge clock);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check("rst_a_ctl", 32'({a_pc_write, a_if_id_write, a_id_ex_write, a_if_id_flush, a_id_ex_flush, a_ex_mem_stall}), 32'd0);
        check("rst_a_state", 32'(a_state), 32'd0);
        check("rst_b_ctl", 32'({b_pc_write, b_if_id_write, b_id_ex_write, b_if_id_flush, b_id_ex_flush, b_ex_mem_stall}), 32'd0);
        check("rst_b_state", 32'(b_state), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("rst_a_stall_count", a_stall_count, 32'd0);
        check("rst_a_flush_count", a_flush_count, 32'd0);
`endif
    endtask

    initial begin
        // Reset with a busy memory and a branch pending: everything must stay low.
        reset_n = 1'b0;
        MemRead_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; rs2_id = 5'd0; uses_rs2_id = 1'b0;
        branch_taken_ex = 1'b1; mem_busy = 1'b1;
        ma = model_reset();
        mb = model_reset();
        @(negedge clock);
        @(negedge clock);
        check_reset_outputs();
        reset_n = 1'b1;

        // Plain run, then rs1 load-use (A: 3 bubbles, B: 1 bubble).
        idle();
        step(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(); idle(); idle();

        // rs2 hazard on x7 with uses_rs2_id, then without, then on x0.
        step(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0);
        idle(); idle(); idle();
        step(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        // Both sources equal rd: still a single hazard.
        step(1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0);
        idle(); idle(); idle();

        // Branch together with a load-use: branch wins.
        step(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0);
        idle(); idle();

        // Freeze for 4 cycles in LU_STALL with two bubbles still owed.
        step(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1);
        step(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1);
        idle(); idle(); idle();

        // Back-to-back branches: second one reloads the flush window.
        step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0);
        step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0);
        idle(); idle();

        // Asynchronous reset between edges while A is mid-flush.
        step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        ma = model_reset();
        mb = model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        idle();

        // Randomized traffic with small register numbers so hazards are common.
        for (int i = 0; i < 400; i++) begin
            bit mr, br, busy, u2;
            logic [4:0] rd, r1, r2;
            br   = ($urandom_range(0, 99) < 15);
            busy = ($urandom_range(0, 99) < 20);
            mr   = (ma.fl > 0) ? 1'b0 : ($urandom_range(0, 99) < 50);
            u2   = ($urandom_range(0, 1) == 1);
            rd   = 5'($urandom_range(0, 3));
            r1   = 5'($urandom_range(0, 3));
            r2   = 5'($urandom_range(0, 3));
            step(mr, rd, r1, r2, u2, br, busy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
